// File: rtl/dht11_pkg.sv
// Shared types, default timing constants and frame helpers for the DHT11 sensor model.
package dht11_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_START_LOW,
      ST_WAIT_REL,
      ST_RESP_DELAY,
      ST_PRE_LOW,
      ST_PRE_HIGH,
      ST_BIT_LOW,
      ST_BIT_HIGH,
      ST_END_LOW
   } dht11_state_e;

   localparam int unsigned DEF_CLK_FREQ_HZ   = 100_000_000;
   localparam int unsigned DEF_START_MIN_US  = 18000;
   localparam int unsigned DEF_RESP_DELAY_US = 30;
   localparam int unsigned DEF_T_PRE_US      = 80;
   localparam int unsigned DEF_T_BIT_LOW_US  = 50;
   localparam int unsigned DEF_T_ZERO_US     = 28;
   localparam int unsigned DEF_T_ONE_US      = 70;

   // Width of the microsecond counter; must hold the longest timed interval.
   localparam int unsigned US_CNT_W = 16;

   typedef logic [39:0] frame_t;

   // 8-bit wrapping sum of the four data bytes.
   function automatic logic [7:0] dht11_chksum(input logic [7:0] a,
                                               input logic [7:0] b,
                                               input logic [7:0] c,
                                               input logic [7:0] d);
      dht11_chksum = a + b + c + d;
   endfunction

   // Assemble the 40-bit frame, optionally flipping the checksum LSB.
   function automatic frame_t dht11_frame(input logic [7:0] hi,
                                          input logic [7:0] hd,
                                          input logic [7:0] ti,
                                          input logic [7:0] td,
                                          input logic       corrupt);
      logic [7:0] cs;
      cs = dht11_chksum(hi, hd, ti, td);
      cs[0] = cs[0] ^ corrupt;
      dht11_frame = {hi, hd, ti, td, cs};
   endfunction

endpackage

// File: rtl/dht11_sensor_model_if.sv
// Single-wire bus and data/status signals of the DHT11 sensor model.
interface dht11_sensor_model_if;

   logic       dq_in;
   logic       dq_drive_low;
   logic [7:0] hum_int;
   logic [7:0] hum_dec;
   logic [7:0] temp_int;
   logic [7:0] temp_dec;
   logic       load;
   logic       corrupt_chksum;
   logic       busy;
   logic       frame_done;

   // Host / stimulus side.
   modport master (
      output dq_in, hum_int, hum_dec, temp_int, temp_dec, load, corrupt_chksum,
      input  dq_drive_low, busy, frame_done
   );

   // Sensor side.
   modport slave (
      input  dq_in, hum_int, hum_dec, temp_int, temp_dec, load, corrupt_chksum,
      output dq_drive_low, busy, frame_done
   );

endinterface

// File: rtl/dht11_us_timer.sv
// Microsecond time base: prescaler producing us_tick plus an elapsed-us counter, both cleared by clr.
module dht11_us_timer
   import dht11_pkg::*;
#(
   parameter int unsigned TICKS_PER_US = 100,
   parameter int unsigned CNT_W        = US_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   output logic             us_tick,
   output logic [CNT_W-1:0] count
);

   localparam int unsigned      PRE_W    = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_US - 1);

   logic [PRE_W-1:0] pre;

   // A tick is suppressed while clearing so stale counts never reach the FSM.
   assign us_tick = !clr && (pre == PRE_LAST);

   // Prescaler and microsecond counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre   <= '0;
         count <= '0;
      end else if (clr) begin
         pre   <= '0;
         count <= '0;
      end else if (pre == PRE_LAST) begin
         pre   <= '0;
         count <= count + 1'b1;
      end else begin
         pre   <= pre + 1'b1;
      end
   end

endmodule

// File: rtl/dht11_sensor_model.sv
// DHT11 sensor responder: qualifies the host start pulse and answers with preamble, 40-bit frame and end pulse.
module dht11_sensor_model
   import dht11_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ   = DEF_CLK_FREQ_HZ,
   parameter int unsigned START_MIN_US  = DEF_START_MIN_US,
   parameter int unsigned RESP_DELAY_US = DEF_RESP_DELAY_US,
   parameter int unsigned T_PRE_US      = DEF_T_PRE_US,
   parameter int unsigned T_BIT_LOW_US  = DEF_T_BIT_LOW_US,
   parameter int unsigned T_ZERO_US     = DEF_T_ZERO_US,
   parameter int unsigned T_ONE_US      = DEF_T_ONE_US
) (
   input  logic                 clk,
   input  logic                 rst,
   dht11_sensor_model_if.slave  bus
);

   localparam int unsigned TICKS_RAW    = CLK_FREQ_HZ / 1_000_000;
   localparam int unsigned TICKS_PER_US = (TICKS_RAW == 0) ? 1 : TICKS_RAW;

   // Terminal counts: a state exits on the tick that completes its duration.
   localparam logic [US_CNT_W-1:0] C_START = US_CNT_W'(START_MIN_US - 1);
   localparam logic [US_CNT_W-1:0] C_RESP  = US_CNT_W'(RESP_DELAY_US - 1);
   localparam logic [US_CNT_W-1:0] C_PRE   = US_CNT_W'(T_PRE_US - 1);
   localparam logic [US_CNT_W-1:0] C_BLOW  = US_CNT_W'(T_BIT_LOW_US - 1);
   localparam logic [US_CNT_W-1:0] C_ZERO  = US_CNT_W'(T_ZERO_US - 1);
   localparam logic [US_CNT_W-1:0] C_ONE   = US_CNT_W'(T_ONE_US - 1);

   dht11_state_e        state;
   logic                dq_m, dq_s;
   logic                own_d1, own_d2;
   logic                host_low;
   logic                tmr_clr;
   logic                us_tick;
   logic [US_CNT_W-1:0] us_count;
   logic [7:0]          sh_hi, sh_hd, sh_ti, sh_td;
   frame_t              frame;
   logic [5:0]          idx;
   logic                cur_bit;

   // Two-flop synchroniser for the bus level; idles high (pulled up).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dq_m <= 1'b1;
         dq_s <= 1'b1;
      end else begin
         dq_m <= bus.dq_in;
         dq_s <= dq_m;
      end
   end

   // Own drive delayed to line up with the synchroniser, so our own low is never seen as the host.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         own_d1 <= 1'b0;
         own_d2 <= 1'b0;
      end else begin
         own_d1 <= bus.dq_drive_low;
         own_d2 <= own_d1;
      end
   end

   assign host_low = !dq_s && !own_d2;
   assign cur_bit  = frame[idx];

   // Shadow data bytes, updated on every load strobe regardless of FSM activity.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_hi <= '0;
         sh_hd <= '0;
         sh_ti <= '0;
         sh_td <= '0;
      end else if (bus.load) begin
         sh_hi <= bus.hum_int;
         sh_hd <= bus.hum_dec;
         sh_ti <= bus.temp_int;
         sh_td <= bus.temp_dec;
      end
   end

   dht11_us_timer #(
      .TICKS_PER_US (TICKS_PER_US),
      .CNT_W        (US_CNT_W)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (tmr_clr),
      .us_tick (us_tick),
      .count   (us_count)
   );

   // Protocol FSM with registered line drive, status flags and timer clear on every state change.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         bus.dq_drive_low <= 1'b0;
         bus.busy     <= 1'b0;
         bus.frame_done <= 1'b0;
         tmr_clr      <= 1'b0;
         frame        <= '0;
         idx          <= '0;
      end else begin
         tmr_clr        <= 1'b0;
         bus.frame_done <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (host_low) begin
                  state   <= ST_START_LOW;
                  tmr_clr <= 1'b1;
               end
            end
            ST_START_LOW: begin
               if (dq_s) begin
                  state <= ST_IDLE;
               end else if (us_tick && us_count == C_START) begin
                  state    <= ST_WAIT_REL;
                  bus.busy <= 1'b1;
                  tmr_clr  <= 1'b1;
               end
            end
            ST_WAIT_REL: begin
               if (dq_s) begin
                  state   <= ST_RESP_DELAY;
                  tmr_clr <= 1'b1;
               end
            end
            ST_RESP_DELAY: begin
               if (us_tick && us_count == C_RESP) begin
                  // A load in this same cycle must land in the frame, so bypass the shadow.
                  if (bus.load)
                     frame <= dht11_frame(bus.hum_int, bus.hum_dec, bus.temp_int,
                                          bus.temp_dec, bus.corrupt_chksum);
                  else
                     frame <= dht11_frame(sh_hi, sh_hd, sh_ti, sh_td, bus.corrupt_chksum);
                  idx              <= 6'd39;
                  state            <= ST_PRE_LOW;
                  bus.dq_drive_low <= 1'b1;
                  tmr_clr          <= 1'b1;
               end
            end
            ST_PRE_LOW: begin
               if (us_tick && us_count == C_PRE) begin
                  state            <= ST_PRE_HIGH;
                  bus.dq_drive_low <= 1'b0;
                  tmr_clr          <= 1'b1;
               end
            end
            ST_PRE_HIGH: begin
               if (us_tick && us_count == C_PRE) begin
                  state            <= ST_BIT_LOW;
                  bus.dq_drive_low <= 1'b1;
                  tmr_clr          <= 1'b1;
               end
            end
            ST_BIT_LOW: begin
               if (us_tick && us_count == C_BLOW) begin
                  state            <= ST_BIT_HIGH;
                  bus.dq_drive_low <= 1'b0;
                  tmr_clr          <= 1'b1;
               end
            end
            ST_BIT_HIGH: begin
               if (us_tick && us_count == (cur_bit ? C_ONE : C_ZERO)) begin
                  bus.dq_drive_low <= 1'b1;
                  tmr_clr          <= 1'b1;
                  if (idx == 6'd0) begin
                     state <= ST_END_LOW;
                  end else begin
                     idx   <= idx - 1'b1;
                     state <= ST_BIT_LOW;
                  end
               end
            end
            ST_END_LOW: begin
               if (us_tick && us_count == C_BLOW) begin
                  state            <= ST_IDLE;
                  bus.dq_drive_low <= 1'b0;
                  bus.busy         <= 1'b0;
                  bus.frame_done   <= 1'b1;
                  tmr_clr          <= 1'b1;
               end
            end
            default: begin
               state            <= ST_IDLE;
               bus.dq_drive_low <= 1'b0;
               bus.busy         <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dht11_sensor_model.sv
// Self-checking bench for dht11_sensor_model: host start pulses, bus decoding, timing and frame checks.
module tb_dht11_sensor_model;

   localparam int T        = 2;    // clocks per microsecond at 2 MHz
   localparam int START_US = 100;  // shortened start qualification to keep runs short
   localparam int HOST_US  = 150;  // valid host start pulse
   localparam int SHORT_US = 50;   // too-short host pulse

   logic clk = 1'b0;
   logic rst;
   logic host_low;

   always #5 clk = ~clk;

   dht11_sensor_model_if bif ();

   // Wired-AND bus with pull-up: low if either end pulls it down.
   assign bif.dq_in = ~(bif.dq_drive_low | host_low);

   dht11_sensor_model #(
      .CLK_FREQ_HZ  (2_000_000),
      .START_MIN_US (START_US)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   typedef struct {
      string       name;
      logic [7:0]  hi, hd, ti, td;
      logic        corrupt;
      logic [39:0] exp;
   } vec_t;

   vec_t        vecs [4];
   int          n_chk  = 0;
   int          n_fail = 0;
   int          bit_no = 0;
   logic [39:0] fr;
   bit          ok;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_rng(input string name, input int act, input int lo, input int hi);
      n_chk++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d cycles, allowed %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic fail_timeout(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: timeout waiting for sensor drive change", name);
   endtask

   // Count negedges until dq_drive_low equals lvl (bounded).
   task automatic wait_for(input logic lvl, input int budget, output int n, output bit got);
      n = 0;
      while (bif.dq_drive_low !== lvl && n < budget) begin
         @(negedge clk);
         n++;
      end
      got = (bif.dq_drive_low === lvl);
   endtask

   task automatic load_bytes(input logic [7:0] hi, hd, ti, td);
      @(negedge clk);
      bif.hum_int  = hi;
      bif.hum_dec  = hd;
      bif.temp_int = ti;
      bif.temp_dec = td;
      bif.load     = 1'b1;
      @(negedge clk);
      bif.load     = 1'b0;
   endtask

   task automatic host_start(input int us);
      @(negedge clk);
      host_low = 1'b1;
      repeat (us * T) @(negedge clk);
      host_low = 1'b0;
   endtask

   // Decode one sensor response starting right after the host releases the line.
   task automatic decode(output logic [39:0] f, output bit done);
      int n;
      int cnt;
      bit got;
      f      = '0;
      done   = 1'b0;
      bit_no = 0;
      wait_for(1'b1, 200 * T, n, got);
      if (!got) begin fail_timeout("resp_delay"); return; end
      chk_rng("resp_delay", n, 30 * T, 30 * T + T + 4);
      chk("busy_during_frame", 64'(bif.busy), 64'd1);
      wait_for(1'b0, 200 * T, n, got);
      if (!got) begin fail_timeout("pre_low"); return; end
      chk_rng("pre_low", n, 80 * T - T, 80 * T + T);
      wait_for(1'b1, 200 * T, n, got);
      if (!got) begin fail_timeout("pre_high"); return; end
      chk_rng("pre_high", n, 80 * T - T, 80 * T + T);
      for (int i = 39; i >= 0; i--) begin
         bit_no = 39 - i;
         wait_for(1'b0, 200 * T, n, got);
         if (!got) begin fail_timeout("bit_low"); return; end
         chk_rng("bit_low", n, 50 * T - T, 50 * T + T);
         wait_for(1'b1, 200 * T, n, got);
         if (!got) begin fail_timeout("bit_high"); return; end
         f[i] = (n > 49 * T);
         if (f[i]) chk_rng("bit_high_one", n, 70 * T - T, 70 * T + T);
         else      chk_rng("bit_high_zero", n, 28 * T - T, 28 * T + T);
      end
      wait_for(1'b0, 200 * T, n, got);
      if (!got) begin fail_timeout("end_low"); return; end
      chk_rng("end_low", n, 50 * T - T, 50 * T + T);
      cnt = 0;
      for (int k = 0; k < 8; k++) begin
         if (bif.frame_done === 1'b1) cnt++;
         @(negedge clk);
      end
      chk("frame_done_pulses", 64'(cnt), 64'd1);
      chk("busy_after_frame", 64'(bif.busy), 64'd0);
      done = 1'b1;
   endtask

   // Watch the bus for a while and report whether anything happened.
   task automatic watch(input int cycles, output bit saw_drive, output bit saw_busy, output bit saw_done);
      saw_drive = 1'b0;
      saw_busy  = 1'b0;
      saw_done  = 1'b0;
      repeat (cycles) begin
         @(negedge clk);
         if (bif.dq_drive_low !== 1'b0) saw_drive = 1'b1;
         if (bif.busy !== 1'b0)         saw_busy  = 1'b1;
         if (bif.frame_done !== 1'b0)   saw_done  = 1'b1;
      end
   endtask

   initial begin
      bit sd, sb, sf;
      int n;
      bit got;

      vecs[0] = '{"frame_basic",    8'h35, 8'h00, 8'h18, 8'h00, 1'b0, 40'h35_00_18_00_4D};
      vecs[1] = '{"frame_wrap",     8'hFF, 8'hFF, 8'h01, 8'h02, 1'b0, 40'hFF_FF_01_02_01};
      vecs[2] = '{"frame_corrupt",  8'hFF, 8'hFF, 8'h01, 8'h02, 1'b1, 40'hFF_FF_01_02_00};
      vecs[3] = '{"frame_alt_bits", 8'hA5, 8'h5A, 8'hC3, 8'h3C, 1'b0, 40'hA5_5A_C3_3C_FE};

      rst                = 1'b1;
      host_low           = 1'b0;
      bif.load           = 1'b0;
      bif.corrupt_chksum = 1'b0;
      bif.hum_int        = '0;
      bif.hum_dec        = '0;
      bif.temp_int       = '0;
      bif.temp_dec       = '0;
      repeat (3) @(negedge clk);
      chk("reset_drive", 64'(bif.dq_drive_low), 64'd0);
      chk("reset_busy",  64'(bif.busy), 64'd0);
      chk("reset_done",  64'(bif.frame_done), 64'd0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // Too-short start pulse is ignored.
      host_start(SHORT_US);
      watch(300 * T, sd, sb, sf);
      chk("short_pulse_drive", 64'(sd), 64'd0);
      chk("short_pulse_busy",  64'(sb), 64'd0);
      chk("short_pulse_done",  64'(sf), 64'd0);

      // Table-driven frames.
      for (int v = 0; v < 4; v++) begin
         bif.corrupt_chksum = vecs[v].corrupt;
         load_bytes(vecs[v].hi, vecs[v].hd, vecs[v].ti, vecs[v].td);
         host_start(HOST_US);
         decode(fr, ok);
         if (ok) chk(vecs[v].name, 64'(fr), 64'(vecs[v].exp));
         repeat (20) @(negedge clk);
      end
      bif.corrupt_chksum = 1'b0;

      // Mid-frame load affects only the following frame.
      load_bytes(8'h35, 8'h00, 8'h18, 8'h00);
      host_start(HOST_US);
      fork
         decode(fr, ok);
         begin
            int g;
            g = 0;
            while (bit_no < 20 && g < 20000) begin
               @(negedge clk);
               g++;
            end
            bif.hum_int  = 8'h40;
            bif.hum_dec  = 8'h00;
            bif.temp_int = 8'h19;
            bif.temp_dec = 8'h00;
            bif.load     = 1'b1;
            @(negedge clk);
            bif.load     = 1'b0;
         end
      join
      if (ok) chk("midload_current", 64'(fr), 64'h35_00_18_00_4D);
      repeat (20) @(negedge clk);
      host_start(HOST_US);
      decode(fr, ok);
      if (ok) chk("midload_next", 64'(fr), 64'h40_00_19_00_59);
      repeat (20) @(negedge clk);

      // Asynchronous reset during the first bit low slot.
      host_start(HOST_US);
      wait_for(1'b1, 200 * T, n, got);
      if (got) wait_for(1'b0, 200 * T, n, got);
      if (got) wait_for(1'b1, 200 * T, n, got);
      if (!got) fail_timeout("reach_bit_low");
      #1 rst = 1'b1;
      #1;
      chk("async_rst_drive", 64'(bif.dq_drive_low), 64'd0);
      chk("async_rst_busy",  64'(bif.busy), 64'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      watch(300 * T, sd, sb, sf);
      chk("post_rst_drive", 64'(sd), 64'd0);
      chk("post_rst_done",  64'(sf), 64'd0);
      host_start(HOST_US);
      decode(fr, ok);
      if (ok) chk("post_rst_zero_frame", 64'(fr), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
